// File: rtl/uart_line_ctrl.sv
// Line-direction and RTS/CTS flow-control controller between the UART config
// registers and the TX/RX shift engines. All outputs are registered.
module uart_line_ctrl #(
    parameter int unsigned LEVEL_W    = 5,
    parameter int unsigned RTS_HIGH   = 12,
    parameter int unsigned RTS_LOW    = 4,
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               master,
    input  logic               flow_control,
    input  logic               baud_tick,
    input  logic               tx_req,
    input  logic               tx_busy,
    input  logic               tx_done,
    input  logic               rx_busy,
    input  logic [LEVEL_W-1:0] rx_level,
    input  logic               cts_n,
    output logic               tx_grant,
    output logic               rx_enable,
    output logic               txd_oe,
    output logic               rts_n,
    output logic [1:0]         fc_state
);
    typedef enum logic [1:0] {SIMPLEX = 2'd0, HALFDUPLEX = 2'd1, FULLDUPLEX = 2'd2} mode_t;
    typedef enum logic [1:0] {FC_IDLE = 2'd0, FC_LOCAL = 2'd1, FC_DIST = 2'd2} fc_state_t;

    localparam logic [LEVEL_W-1:0] LVL_HIGH   = LEVEL_W'(RTS_HIGH);
    localparam logic [LEVEL_W-1:0] LVL_LOW    = LEVEL_W'(RTS_LOW);
    localparam logic [3:0]         GUARD_INIT = 4'(TURNAROUND);
    localparam logic [7:0]         BURST_MAX  = 8'(MAX_BURST);

    fc_state_t  state, state_next;
    mode_t      cfg_mode, eff_mode;
    logic       cfg_master, eff_master;
    logic       cfg_fc, eff_fc;
    logic       cfg_load;
    logic [1:0] cts_sync;
    logic       cts_ok;
    logic [3:0] guard, guard_next;
    logic [7:0] burst, burst_next;
    logic       burst_limit;
    logic       rx_stop, rx_stop_next;
    logic       grant_next, rx_en_next, oe_next, rts_next;

    // New config takes effect on the same edge it is loaded, keeping 1-cycle latency.
    always_comb begin
        cfg_load   = (state == FC_IDLE) && !tx_busy && !rx_busy;
        eff_mode   = cfg_load ? mode_t'(mode) : cfg_mode;
        eff_master = cfg_load ? master : cfg_master;
        eff_fc     = cfg_load ? flow_control : cfg_fc;
        cts_ok     = !eff_fc || !cts_sync[1];

        state_next = state;
        guard_next = guard;
        burst_next = burst;
        if (state == FC_IDLE && baud_tick && guard != '0)
            guard_next = guard - 4'd1;
        if (state == FC_LOCAL && tx_done && burst != '1)
            burst_next = burst + 8'd1;
        burst_limit = (BURST_MAX != '0) && (burst_next >= BURST_MAX);

        if (eff_mode == HALFDUPLEX) begin
            unique case (state)
                FC_IDLE: begin
                    if (rx_busy) begin
                        state_next = FC_DIST;
                    end else if (tx_req && cts_ok && guard == '0) begin
                        state_next  = FC_LOCAL;
                        burst_next  = '0;
                        burst_limit = (BURST_MAX != '0) && (BURST_MAX == '0);
                    end
                end
                FC_LOCAL: begin
                    if (!tx_busy && (!tx_req || burst_limit)) begin
                        state_next = FC_IDLE;
                        guard_next = GUARD_INIT;
                    end
                end
                default: begin
                    if (!rx_busy) begin
                        state_next = FC_IDLE;
                        guard_next = GUARD_INIT;
                    end
                end
            endcase
        end else begin
            state_next = FC_IDLE;
        end

        grant_next = 1'b0;
        rx_en_next = 1'b1;
        oe_next    = 1'b0;
        if (eff_mode == FULLDUPLEX) begin
            oe_next    = 1'b1;
            grant_next = tx_req && cts_ok;
        end else if (eff_mode == HALFDUPLEX) begin
            if (state_next == FC_LOCAL) begin
                rx_en_next = 1'b0;
                oe_next    = 1'b1;
                grant_next = tx_req && cts_ok && !burst_limit;
            end
        end else if (eff_master) begin
            rx_en_next = 1'b0;
            oe_next    = 1'b1;
            grant_next = tx_req && cts_ok;
        end

        rx_stop_next = rx_stop;
        if (rx_level >= LVL_HIGH)
            rx_stop_next = 1'b1;
        else if (rx_level <= LVL_LOW)
            rx_stop_next = 1'b0;
        rts_next = eff_fc && (rx_stop_next || !rx_en_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FC_IDLE;
            cfg_mode   <= SIMPLEX;
            cfg_master <= 1'b0;
            cfg_fc     <= 1'b0;
            cts_sync   <= '1;
            guard      <= '0;
            burst      <= '0;
            rx_stop    <= 1'b0;
            tx_grant   <= 1'b0;
            rx_enable  <= 1'b0;
            txd_oe     <= 1'b0;
            rts_n      <= 1'b1;
        end else begin
            state      <= state_next;
            cfg_mode   <= eff_mode;
            cfg_master <= eff_master;
            cfg_fc     <= eff_fc;
            cts_sync   <= {cts_sync[0], cts_n};
            guard      <= guard_next;
            burst      <= burst_next;
            rx_stop    <= rx_stop_next;
            tx_grant   <= grant_next;
            rx_enable  <= rx_en_next;
            txd_oe     <= oe_next;
            rts_n      <= rts_next;
        end
    end

    assign fc_state = state;
endmodule

// File: tb/tb_uart_line_ctrl.sv
// Directed self-checking bench for uart_line_ctrl with default parameters
// (RTS 12/4, TURNAROUND 2, MAX_BURST 4).
module tb_uart_line_ctrl;
    logic       clk = 1'b0;
    logic       rst, master, flow_control, baud_tick, tx_req, tx_busy, tx_done, rx_busy, cts_n;
    logic [1:0] mode;
    logic [4:0] rx_level;
    logic       tx_grant, rx_enable, txd_oe, rts_n;
    logic [1:0] fc_state;

    int unsigned tests = 0;
    int unsigned fails = 0;

    uart_line_ctrl #(.LEVEL_W(5), .RTS_HIGH(12), .RTS_LOW(4), .TURNAROUND(2), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .master(master), .flow_control(flow_control),
        .baud_tick(baud_tick), .tx_req(tx_req), .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_busy(rx_busy), .rx_level(rx_level), .cts_n(cts_n), .tx_grant(tx_grant),
        .rx_enable(rx_enable), .txd_oe(txd_oe), .rts_n(rts_n), .fc_state(fc_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd2; master = 1'b1; flow_control = 1'b1; baud_tick = 1'b0;
        tx_req = 1'b1; tx_busy = 1'b0; tx_done = 1'b0; rx_busy = 1'b0; rx_level = '0; cts_n = 1'b0;
        tick(); tick();
        tests++; if ({tx_grant, rx_enable, txd_oe, rts_n} !== 4'b0001) begin fails++;
            $display("FAIL reset_outputs got %b exp 0001", {tx_grant, rx_enable, txd_oe, rts_n}); end
        tests++; if (fc_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", fc_state); end
        mode = 2'd0; master = 1'b0; flow_control = 1'b0; tx_req = 1'b0;
        rst = 1'b0;
        tick();
        tests++; if ({tx_grant, rx_enable, txd_oe, rts_n} !== 4'b0100) begin fails++;
            $display("FAIL simplex_slave got %b exp 0100", {tx_grant, rx_enable, txd_oe, rts_n}); end
    endtask

    task automatic test_cts();
        mode = 2'd2; flow_control = 1'b1; cts_n = 1'b0; tx_req = 1'b1;
        tick(); tick(); tick();
        tests++; if ({tx_grant, rx_enable, txd_oe} !== 3'b111) begin fails++;
            $display("FAIL fd_grant got %b exp 111", {tx_grant, rx_enable, txd_oe}); end
        tx_busy = 1'b1;
        cts_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++; if (tx_grant !== (i < 3)) begin fails++;
                $display("FAIL cts_latency_c%0d got %b exp %b", i, tx_grant, (i < 3)); end
        end
        tests++; if (fc_state !== 2'd0) begin fails++; $display("FAIL fd_state got %0d exp 0", fc_state); end
        tx_busy = 1'b0;
        flow_control = 1'b0;
        tick();
        tests++; if (tx_grant !== 1'b1) begin fails++; $display("FAIL fc_off_grant got %b exp 1", tx_grant); end
        tx_req = 1'b0; cts_n = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_rts();
        flow_control = 1'b1;
        for (int l = 0; l <= 12; l++) begin
            rx_level = 5'(l);
            tick();
            tests++; if (rts_n !== (l >= 12)) begin fails++;
                $display("FAIL rts_up_l%0d got %b exp %b", l, rts_n, (l >= 12)); end
        end
        for (int l = 11; l >= 0; l--) begin
            rx_level = 5'(l);
            tick();
            tests++; if (rts_n !== (l > 4)) begin fails++;
                $display("FAIL rts_down_l%0d got %b exp %b", l, rts_n, (l > 4)); end
        end
        flow_control = 1'b0;
        tick();
    endtask

    task automatic test_deferred_config();
        mode = 2'd2; tx_req = 1'b1;
        tick(); tick();
        tx_busy = 1'b1;
        tick();
        mode = 2'd0; master = 1'b0;
        tick(); tick(); tick();
        tests++; if ({tx_grant, rx_enable, txd_oe} !== 3'b111) begin fails++;
            $display("FAIL cfg_deferred got %b exp 111", {tx_grant, rx_enable, txd_oe}); end
        tx_busy = 1'b0;
        tick();
        tests++; if ({tx_grant, rx_enable, txd_oe} !== 3'b010) begin fails++;
            $display("FAIL cfg_applied got %b exp 010", {tx_grant, rx_enable, txd_oe}); end
        tx_req = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        mode = 2'd1;
        tick();
        tx_req = 1'b1; rx_busy = 1'b1;
        tick();
        tests++; if ({fc_state, tx_grant, txd_oe, rx_enable} !== 5'b10_001) begin fails++;
            $display("FAIL collision got %b exp 10001", {fc_state, tx_grant, txd_oe, rx_enable}); end
        tx_req = 1'b0; rx_busy = 1'b0;
        tick();
        tests++; if (fc_state !== 2'd0) begin fails++; $display("FAIL dist_exit got %0d exp 0", fc_state); end
    endtask

    task automatic test_burst();
        int busy_left = 0;
        int dones = 0;
        int starts = 0;
        bit was_local = 1'b0;
        bit done_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            baud_tick = 1'b1; tick(); baud_tick = 1'b0; tick();
        end
        tx_req = 1'b1;
        for (int c = 0; c < 300 && !done_seen; c++) begin
            tick();
            if (fc_state == 2'd1) was_local = 1'b1;
            if (was_local && fc_state == 2'd0) done_seen = 1'b1;
            if (busy_left > 0) begin
                tx_busy = 1'b1; tx_done = (busy_left == 1); busy_left--;
                if (tx_done) dones++;
            end else begin
                tx_busy = 1'b0; tx_done = 1'b0;
                if (tx_grant && tx_req) begin busy_left = 6; starts++; end
            end
        end
        tx_busy = 1'b0; tx_done = 1'b0;
        tests++; if (!done_seen) begin fails++; $display("FAIL burst_timeout got 0 exp 1"); end
        tests++; if (dones != 4) begin fails++; $display("FAIL burst_done_count got %0d exp 4", dones); end
        tests++; if (starts != 4) begin fails++; $display("FAIL burst_start_count got %0d exp 4", starts); end
        tick(); tick(); tick();
        tests++; if ({fc_state, tx_grant} !== 3'b00_0) begin fails++;
            $display("FAIL guard_hold0 got %b exp 000", {fc_state, tx_grant}); end
        baud_tick = 1'b1; tick(); baud_tick = 1'b0; tick();
        tests++; if (fc_state !== 2'd0) begin fails++; $display("FAIL guard_hold1 got %0d exp 0", fc_state); end
        baud_tick = 1'b1; tick(); baud_tick = 1'b0;
        tests++; if (fc_state !== 2'd0) begin fails++; $display("FAIL guard_hold2 got %0d exp 0", fc_state); end
        tick();
        tests++; if ({fc_state, tx_grant, txd_oe} !== 4'b01_11) begin fails++;
            $display("FAIL reacquire got %b exp 0111", {fc_state, tx_grant, txd_oe}); end
        tx_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        baud_tick = 1'b1; tick(); tick(); baud_tick = 1'b0;
        tx_req = 1'b1;
        tick();
        tests++; if (fc_state !== 2'd1) begin fails++; $display("FAIL rmb_local got %0d exp 1", fc_state); end
        tx_busy = 1'b1; tick(); tx_done = 1'b1; tick(); tx_done = 1'b0;
        rst = 1'b1;
        tick();
        tests++; if ({fc_state, tx_grant, rx_enable, txd_oe, rts_n} !== 6'b00_0001) begin fails++;
            $display("FAIL rmb_reset got %b exp 000001", {fc_state, tx_grant, rx_enable, txd_oe, rts_n}); end
        rst = 1'b0; tx_busy = 1'b0;
        tick();
        tests++; if ({fc_state, tx_grant} !== 3'b01_1) begin fails++;
            $display("FAIL rmb_guard_clear got %b exp 011", {fc_state, tx_grant}); end
        tx_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cts();
        test_rts();
        test_deferred_config();
        test_collision();
        test_burst();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
